pipeline_hazard_ctrl: RTL and testbench

Central hazard and flow controller for the 5-stage pipeline (F, D, X, M, W). It does three things:
- Decides per-cycle write enables, flushes and bubble insertion for the PC, FD, DX and XM latches.
- Sequences the multicycle mult/div unit.
- Selects the PC redirect source.
It emits per-cycle event pulses (no-ops inserted, mispredicts) for the performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 19 +
 rtl/md_sequencer.sv | 63 ++++++
 rtl/pipeline_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam logic [1:0] RSEL_SEQ = 2'd0;
  localparam logic [1:0] RSEL_FD  = 2'd1;
  localparam logic [1:0] RSEL_DX  = 2'd2;

  localparam logic [2:0] NOOP_LU = 3'd1;
  localparam logic [2:0] NOOP_FD = 3'd1;
  localparam logic [2:0] NOOP_DX = 3'd2;
  localparam logic [2:0] NOOP_MD = 3'd1;

endpackage

// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - mult/div start/wait/done sequencer with a ready watchdog
module md_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic start_req_i,
  input  logic md_ready_i,
  output logic busy_o,
  output logic done_o,
  output logic md_start_o,
  output logic md_error_o
);

  localparam int WD_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

  md_state_t       state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    md_start_o = 1'b0;
    md_error_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_req_i) begin
          state_d    = BUSY;
          wd_d       = '0;
          md_start_o = 1'b1;
        end
      end
      BUSY: begin
        wd_d = wd_q + 1'b1;
        if (md_ready_i) begin
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          state_d    = IDLE;
          md_error_o = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = (state_q == DONE);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage hazard/flow controller; PIPE_PERF_COUNT_EN adds event counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] fd_rs,
  input  logic [REG_AW-1:0] fd_rt,
  input  logic              fd_uses_rs,
  input  logic              fd_uses_rt,
  input  logic              fd_jump,
  input  logic [REG_AW-1:0] dx_rd,
  input  logic              dx_is_load,
  input  logic              dx_branch,
  input  logic              dx_taken,
  input  logic              dx_pred_taken,
  input  logic              dx_jr,
  input  logic              dx_md,
  input  logic              md_ready,
  output logic              pc_we,
  output logic              fd_we,
  output logic              dx_we,
  output logic              fd_flush,
  output logic              dx_bubble,
  output logic              xm_bubble,
  output logic              md_start,
  output logic              md_error,
  output logic [1:0]        redirect_sel,
  output logic [2:0]        ev_noops,
  output logic              ev_mispredict,
  output logic [CNT_W-1:0]  cnt_noops,
  output logic [CNT_W-1:0]  cnt_mispredicts
);

  logic load_use, br_mispred, dx_redir;
  logic md_busy, md_done, seq_start, seq_error;

  assign load_use = dx_is_load && (dx_rd != '0) &&
                    ((fd_uses_rs && (fd_rs == dx_rd)) || (fd_uses_rt && (fd_rt == dx_rd)));
  assign br_mispred = dx_branch && (dx_taken != dx_pred_taken);
  assign dx_redir   = dx_jr || br_mispred;

  md_sequencer #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_seq (
    .clock      (clock),
    .reset      (reset),
    .start_req_i(dx_md && !dx_redir),
    .md_ready_i (md_ready),
    .busy_o     (md_busy),
    .done_o     (md_done),
    .md_start_o (seq_start),
    .md_error_o (seq_error)
  );

  assign md_start = seq_start && !reset;
  assign md_error = seq_error && !reset;

  // DONE falls through to the normal priority chain; X still holds the mult/div there.
  always_comb begin
    pc_we         = 1'b1;
    fd_we         = 1'b1;
    dx_we         = 1'b1;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    xm_bubble     = 1'b0;
    redirect_sel  = RSEL_SEQ;
    ev_noops      = 3'd0;
    ev_mispredict = 1'b0;
    if (reset) begin
      pc_we = 1'b1;
    end else if (md_busy) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_we     = 1'b0;
      xm_bubble = 1'b1;
      ev_noops  = NOOP_MD;
    end else if (dx_redir) begin
      fd_flush      = 1'b1;
      dx_bubble     = 1'b1;
      redirect_sel  = RSEL_DX;
      ev_noops      = NOOP_DX;
      ev_mispredict = br_mispred && !dx_jr;
    end else if (load_use) begin
      pc_we     = 1'b0;
      fd_we     = 1'b0;
      dx_bubble = 1'b1;
      ev_noops  = NOOP_LU;
    end else if (fd_jump) begin
      fd_flush     = 1'b1;
      redirect_sel = RSEL_FD;
      ev_noops     = NOOP_FD;
    end
  end

`ifdef PIPE_PERF_COUNT_EN
  logic [CNT_W-1:0] cnt_noops_q, cnt_noops_d;
  logic [CNT_W-1:0] cnt_mis_q, cnt_mis_d;
  logic [CNT_W:0]   noops_sum;

  always_comb begin
    noops_sum   = {1'b0, cnt_noops_q} + {{(CNT_W-2){1'b0}}, ev_noops};
    cnt_noops_d = noops_sum[CNT_W] ? '1 : noops_sum[CNT_W-1:0];
    cnt_mis_d   = (&cnt_mis_q) ? cnt_mis_q : cnt_mis_q + {{(CNT_W-1){1'b0}}, ev_mispredict};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_noops_q <= '0;
      cnt_mis_q   <= '0;
    end else begin
      cnt_noops_q <= cnt_noops_d;
      cnt_mis_q   <= cnt_mis_d;
    end
  end

  assign cnt_noops       = cnt_noops_q;
  assign cnt_mispredicts = cnt_mis_q;
`else
  assign cnt_noops       = '0;
  assign cnt_mispredicts = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed bench with per-cycle reference model for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW     = 5;
  localparam int MD_TIMEOUT = 40;
  localparam int CNT_W      = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] fd_rs, fd_rt, dx_rd;
  logic              fd_uses_rs, fd_uses_rt, fd_jump;
  logic              dx_is_load, dx_branch, dx_taken, dx_pred_taken, dx_jr, dx_md, md_ready;
  logic              pc_we, fd_we, dx_we, fd_flush, dx_bubble, xm_bubble, md_start, md_error;
  logic [1:0]        redirect_sel;
  logic [2:0]        ev_noops;
  logic              ev_mispredict;
  logic [CNT_W-1:0]  cnt_noops, cnt_mispredicts;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .REG_AW(REG_AW), .MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .fd_jump(fd_jump), .dx_rd(dx_rd), .dx_is_load(dx_is_load), .dx_branch(dx_branch),
    .dx_taken(dx_taken), .dx_pred_taken(dx_pred_taken), .dx_jr(dx_jr), .dx_md(dx_md),
    .md_ready(md_ready), .pc_we(pc_we), .fd_we(fd_we), .dx_we(dx_we), .fd_flush(fd_flush),
    .dx_bubble(dx_bubble), .xm_bubble(xm_bubble), .md_start(md_start), .md_error(md_error),
    .redirect_sel(redirect_sel), .ev_noops(ev_noops), .ev_mispredict(ev_mispredict),
    .cnt_noops(cnt_noops), .cnt_mispredicts(cnt_mispredicts)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: "waiting" = mult/div outstanding, "waited" = stall cycles spent so far.
  bit     m_waiting = 0;
  bit     m_finishing = 0;
  int     m_waited = 0;
  longint m_noops = 0;
  longint m_mis = 0;

  always @(negedge clock) begin
    bit lu, mis, redir, e_pc, e_fd, e_dx, e_ff, e_db, e_xb, e_start, e_err, e_mis;
    int e_sel, e_noops;
    longint cap, e_cnt_n, e_cnt_m;
    lu    = dx_is_load && dx_rd != 0 &&
            ((fd_uses_rs && fd_rs == dx_rd) || (fd_uses_rt && fd_rt == dx_rd));
    mis   = dx_branch && (dx_taken != dx_pred_taken);
    redir = dx_jr || mis;
    e_pc = 1; e_fd = 1; e_dx = 1; e_ff = 0; e_db = 0; e_xb = 0; e_mis = 0;
    e_sel = 0; e_noops = 0;
    e_start = !reset && !m_waiting && !m_finishing && dx_md && !redir;
    e_err   = !reset && m_waiting && !md_ready && (m_waited == MD_TIMEOUT - 1);
    if (reset) begin
      e_pc = 1;
    end else if (m_waiting) begin
      e_pc = 0; e_fd = 0; e_dx = 0; e_xb = 1; e_noops = 1;
    end else if (redir) begin
      e_ff = 1; e_db = 1; e_sel = 2; e_noops = 2; e_mis = mis && !dx_jr;
    end else if (lu) begin
      e_pc = 0; e_fd = 0; e_db = 1; e_noops = 1;
    end else if (fd_jump) begin
      e_ff = 1; e_sel = 1; e_noops = 1;
    end
    cap = (64'd1 << CNT_W) - 1;
`ifdef PIPE_PERF_COUNT_EN
    e_cnt_n = (m_noops > cap) ? cap : m_noops;
    e_cnt_m = (m_mis > cap) ? cap : m_mis;
`else
    e_cnt_n = 0;
    e_cnt_m = 0;
`endif
    chk("pc_we", pc_we, e_pc);
    chk("fd_we", fd_we, e_fd);
    chk("dx_we", dx_we, e_dx);
    chk("fd_flush", fd_flush, e_ff);
    chk("dx_bubble", dx_bubble, e_db);
    chk("xm_bubble", xm_bubble, e_xb);
    chk("md_start", md_start, e_start);
    chk("md_error", md_error, e_err);
    chk("redirect_sel", redirect_sel, e_sel);
    chk("ev_noops", ev_noops, e_noops);
    chk("ev_mispredict", ev_mispredict, e_mis);
    chk("cnt_noops", cnt_noops, e_cnt_n);
    chk("cnt_mispredicts", cnt_mispredicts, e_cnt_m);
    if (reset) begin
      m_waiting = 0; m_finishing = 0; m_waited = 0; m_noops = 0; m_mis = 0;
    end else begin
      m_noops += e_noops;
      m_mis   += e_mis;
      if (m_waiting) begin
        if (md_ready) begin
          m_waiting = 0; m_finishing = 1;
        end else if (e_err) begin
          m_waiting = 0;
        end else begin
          m_waited++;
        end
      end else if (m_finishing) begin
        m_finishing = 0;
      end else if (e_start) begin
        m_waiting = 1; m_waited = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    fd_rs = 0; fd_rt = 0; dx_rd = 0; fd_uses_rs = 0; fd_uses_rt = 0; fd_jump = 0;
    dx_is_load = 0; dx_branch = 0; dx_taken = 0; dx_pred_taken = 0; dx_jr = 0;
    dx_md = 0; md_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    clear_inputs();
    reset = 1;
    fd_jump = 1; dx_md = 1; dx_jr = 1;
    tick(); tick(); #3;
    chk("lit_reset_pc_we", pc_we, 1);
    chk("lit_reset_fd_flush", fd_flush, 0);
    chk("lit_reset_md_start", md_start, 0);
    chk("lit_reset_redirect", redirect_sel, 0);
    tick();
    clear_inputs(); reset = 0;

    // load-use on rs
    dx_is_load = 1; dx_rd = 5; fd_rs = 5; fd_uses_rs = 1; #3;
    chk("lit_lu_pc_we", pc_we, 0);
    chk("lit_lu_fd_we", fd_we, 0);
    chk("lit_lu_dx_bubble", dx_bubble, 1);
    chk("lit_lu_ev_noops", ev_noops, 1);
    tick(); clear_inputs(); #3;
    chk("lit_after_lu_pc_we", pc_we, 1);
    tick();

    // load-use on rt with a pending jump: jump deferred
    dx_is_load = 1; dx_rd = 9; fd_rt = 9; fd_uses_rt = 1; fd_jump = 1; #3;
    chk("lit_lu_jump_sel", redirect_sel, 0);
    chk("lit_lu_jump_flush", fd_flush, 0);
    tick(); dx_is_load = 0; #3;
    chk("lit_jump_after_lu_sel", redirect_sel, 1);
    tick(); clear_inputs();

    // r0 never stalls; unused operand never stalls
    dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_uses_rs = 1; #3;
    chk("lit_r0_pc_we", pc_we, 1);
    tick(); dx_rd = 7; fd_rs = 7; fd_uses_rs = 0; fd_rt = 7; fd_uses_rt = 0; tick(); clear_inputs();

    // mispredict beats jump
    dx_branch = 1; dx_taken = 1; dx_pred_taken = 0; fd_jump = 1; #3;
    chk("lit_mp_sel", redirect_sel, 2);
    chk("lit_mp_flush", fd_flush, 1);
    chk("lit_mp_bubble", dx_bubble, 1);
    chk("lit_mp_ev", ev_mispredict, 1);
    chk("lit_mp_noops", ev_noops, 2);
    tick(); clear_inputs();
    dx_branch = 1; dx_taken = 0; dx_pred_taken = 1; tick();
    dx_taken = 1; dx_pred_taken = 1; #3;
    chk("lit_good_pred_sel", redirect_sel, 0);
    tick(); clear_inputs();
    dx_jr = 1; dx_is_load = 1; dx_rd = 3; fd_rs = 3; fd_uses_rs = 1; #3;
    chk("lit_jr_sel", redirect_sel, 2);
    chk("lit_jr_mispredict", ev_mispredict, 0);
    tick(); clear_inputs();
    md_ready = 1; tick(); clear_inputs();
    dx_md = 1; dx_jr = 1; #3;
    chk("lit_md_redir_no_start", md_start, 0);
    tick(); clear_inputs();

    // mult/div with ready on the 17th stall cycle
    reset = 1; tick(); reset = 0;
    dx_md = 1; #3;
    chk("lit_md_start", md_start, 1);
    tick(); dx_md = 0;
    for (int i = 1; i <= 17; i++) begin
      md_ready = (i == 17); #3;
      chk("lit_md_busy_pc_we", pc_we, 0);
      chk("lit_md_busy_xm_bubble", xm_bubble, 1);
      chk("lit_md_busy_start", md_start, 0);
      tick();
    end
    md_ready = 1; dx_md = 1; #3;
    chk("lit_md_done_pc_we", pc_we, 1);
    chk("lit_md_done_xm_bubble", xm_bubble, 0);
    chk("lit_md_done_start", md_start, 0);
    tick(); clear_inputs(); #3;
`ifdef PIPE_PERF_COUNT_EN
    chk("lit_md_cnt_noops", cnt_noops, 17);
`endif
    tick();

    // timeout
    dx_md = 1; tick(); dx_md = 0;
    for (int i = 1; i <= 40; i++) begin
      #3;
      chk("lit_to_md_error", md_error, (i == 40) ? 64'd1 : 64'd0);
      chk("lit_to_pc_we", pc_we, 0);
      tick();
    end
    #3;
    chk("lit_to_restored_pc_we", pc_we, 1);
    chk("lit_to_no_error", md_error, 0);
    tick();

    // reset in the 5th stall cycle
    dx_md = 1; tick(); dx_md = 0;
    for (int i = 1; i <= 4; i++) tick();
    reset = 1; #3;
    chk("lit_rst_busy_pc_we", pc_we, 1);
    chk("lit_rst_busy_error", md_error, 0);
    tick(); reset = 0; #3;
    chk("lit_rst_after_pc_we", pc_we, 1);
    chk("lit_rst_after_xm", xm_bubble, 0);
    chk("lit_rst_after_cnt", cnt_noops, 0);
    for (int i = 0; i < 45; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
